// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment scanner: per-digit decode, leading-zero blanking,
// decimal points, and a display word that only changes at frame boundaries.
module hex_display_scanner #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_in_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic                  enable_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_sel_o,
  output logic                  frame_done_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     LAST_PRE = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  logic [4*DIGITS-1:0] pend_word_q, pend_word_d, disp_word_q, disp_word_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                wrapped_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   sel_q;
  logic                fd_q;

  logic slot_end, wrap;
  assign slot_end = enable_i && (pre_q == LAST_PRE);
  assign wrap     = slot_end && (idx_q == LAST_IDX);

  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (enable_i) begin
      pre_d = slot_end ? '0 : pre_q + 1'b1;
      if (slot_end) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // While scanning, loads wait in pending until the frame wraps; a load landing
  // exactly on the wrap (or while disabled) goes straight to the display.
  always_comb begin
    pend_word_d  = pend_word_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_word_d  = disp_word_q;
    disp_dp_d    = disp_dp_q;
    if (!enable_i || wrap) begin
      if (load_i) begin
        disp_word_d = value_i;
        disp_dp_d   = dp_in_i;
      end else if (wrap && pend_valid_q) begin
        disp_word_d = pend_word_q;
        disp_dp_d   = pend_dp_q;
      end
      if (load_i || wrap) pend_valid_d = 1'b0;
    end else if (load_i) begin
      pend_word_d  = value_i;
      pend_dp_d    = dp_in_i;
      pend_valid_d = 1'b1;
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blank, all_zero;
  logic [DIGITS-1:0] cur_sel;

  // Walk from the top nibble down so all_zero means "this and every higher nibble is 0".
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    all_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (disp_word_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        cur_nib    = disp_word_q[4*k +: 4];
        cur_dp     = disp_dp_q[k];
        cur_blank  = all_zero && (k != 0);
        cur_sel[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_word_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_word_q  <= '0;
      disp_dp_q    <= '0;
      pre_q        <= '0;
      idx_q        <= '0;
      wrapped_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACTIVE_LOW;
      sel_q        <= SEL_OFF;
      fd_q         <= 1'b0;
    end else begin
      pend_word_q  <= pend_word_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_word_q  <= disp_word_d;
      disp_dp_q    <= disp_dp_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      if (enable_i) begin
        seg_q     <= (blank_lz_i && cur_blank) ? SEG_OFF : (decode(cur_nib) ^ SEG_OFF);
        dp_q      <= cur_dp ^ SEG_ACTIVE_LOW;
        sel_q     <= cur_sel ^ SEL_OFF;
        fd_q      <= wrapped_q;
        wrapped_q <= wrap;
      end else begin
        seg_q <= SEG_OFF;
        dp_q  <= SEG_ACTIVE_LOW;
        sel_q <= SEL_OFF;
        fd_q  <= 1'b0;
      end
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign digit_sel_o  = sel_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: decode table, scan timing, tear-free loads,
// blanking, enable pause, pin polarity and asynchronous reset.
module tb_hex_display_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [15:0] value_a;
  logic [3:0]  dp_a, sel_a;
  logic        load_a, blz_a, en_a, dpo_a, fd_a;
  logic [6:0]  seg_a;

  logic [7:0]  value_b;
  logic [1:0]  dp_b, sel_b;
  logic        load_b, blz_b, en_b, dpo_b, fd_b;
  logic [6:0]  seg_b;

  hex_display_scanner #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .value_i(value_a), .dp_in_i(dp_a), .load_i(load_a),
    .blank_lz_i(blz_a), .enable_i(en_a), .seg_o(seg_a), .dp_o(dpo_a),
    .digit_sel_o(sel_a), .frame_done_o(fd_a));

  hex_display_scanner #(.DIGITS(2), .REFRESH_DIV(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .value_i(value_b), .dp_in_i(dp_b), .load_i(load_b),
    .blank_lz_i(blz_b), .enable_i(en_b), .seg_o(seg_b), .dp_o(dpo_b),
    .digit_sel_o(sel_b), .frame_done_o(fd_b));

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SA = 7'b1110111, SB = 7'b0011111;
  localparam logic [6:0] SC = 7'b1001110, SD = 7'b0111101, SE = 7'b1001111, SF = 7'b1000111;
  localparam logic [6:0] OFF = 7'b0000000;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][6:0] seg;   // expected segments, index = digit
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_a(input string name, input logic [6:0] s, input logic d,
                       input logic [3:0] sel, input logic fd);
    chk(name, {19'd0, seg_a, dpo_a, sel_a, fd_a}, {19'd0, s, d, sel, fd});
  endtask

  task automatic chk_b(input string name, input logic [6:0] s, input logic d,
                       input logic [1:0] sel, input logic fd);
    chk(name, {21'd0, seg_b, dpo_b, sel_b, fd_b}, {21'd0, s, d, sel, fd});
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    while (fd_a !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (fd_a !== 1'b1) begin
      failures++;
      $display("FAIL %s: frame_done not seen within 40 cycles", name);
    end
  endtask

  // Starts on a frame_done sample; checks all 16 cycles of that frame, ends on cycle 15.
  task automatic check_frame(input string name, input logic [3:0][6:0] segs, input logic [3:0] dps);
    logic [3:0] one_hot;
    for (int c = 0; c < 16; c++) begin
      one_hot = 4'(1) << (c / 4);
      chk_a($sformatf("%s c%0d", name, c), segs[c/4], dps[c/4], one_hot, c == 0);
      if (c < 15) tick();
    end
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    value_a = v;
    dp_a    = d;
    load_a  = 1'b1;
    tick();
    load_a  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hA3F7, 4'b0000, 1'b0, {SA, S3, SF, S7}};
    vecs[1] = '{16'h1234, 4'b0101, 1'b0, {S1, S2, S3, S4}};
    vecs[2] = '{16'h0050, 4'b1000, 1'b1, {OFF, OFF, S5, S0}};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, {OFF, OFF, OFF, S0}};
    vecs[4] = '{16'h6E9D, 4'b0010, 1'b0, {S6, SE, S9, SD}};
    vecs[5] = '{16'hC8B0, 4'b0000, 1'b1, {SC, S8, SB, S0}};
    vecs[6] = '{16'h0005, 4'b1111, 1'b0, {S0, S0, S0, S5}};

    rst_n = 1'b0;
    value_a = '0; dp_a = '0; load_a = 1'b0; blz_a = 1'b0; en_a = 1'b0;
    value_b = '0; dp_b = '0; load_b = 1'b0; blz_b = 1'b0; en_b = 1'b0;
    repeat (3) tick();
    chk_a("reset_a", OFF, 1'b0, 4'b0000, 1'b0);
    chk_b("reset_b", 7'b1111111, 1'b1, 2'b11, 1'b0);

    // First slots after reset: digit 0 shows '0' for four cycles, then digit 1.
    rst_n = 1'b1;
    en_a  = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk_a($sformatf("startup t%0d", t), S0, 1'b0, (t <= 4) ? 4'b0001 : 4'b0010, 1'b0);
    end

    for (int i = 0; i < 7; i++) begin
      wait_fd($sformatf("vec%0d pre", i));
      blz_a = vecs[i].blz;
      load_word(vecs[i].value, vecs[i].dp);
      wait_fd($sformatf("vec%0d post", i));
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp);
    end

    // Tear-free: load during digit 2 leaves the rest of the frame on the old word.
    wait_fd("tear pre");
    repeat (9) tick();
    load_word(16'h1234, 4'b0000);
    for (int c = 10; c < 16; c++) begin
      chk_a($sformatf("tear old c%0d", c), S0, 1'b1, (c < 12) ? 4'b0100 : 4'b1000, 1'b0);
      if (c < 15) tick();
    end
    tick();
    check_frame("tear new", {S1, S2, S3, S4}, 4'b0000);

    // Two loads in one frame: only the second is ever displayed.
    wait_fd("dbl pre");
    repeat (2) tick();
    load_word(16'h1111, 4'b0000);
    repeat (6) tick();
    load_word(16'h2222, 4'b0000);
    wait_fd("dbl post");
    check_frame("dbl", {S2, S2, S2, S2}, 4'b0000);

    // Load on the wrap edge overrides an earlier pending load and leaves nothing pending.
    wait_fd("wrap pre");
    repeat (5) tick();
    load_word(16'h1111, 4'b0000);
    repeat (8) tick();
    value_a = 16'hA3F7;
    load_a  = 1'b1;
    tick();
    load_a  = 1'b0;
    chk_a("wrap last slot", S2, 1'b0, 4'b1000, 1'b0);
    tick();
    check_frame("wrap new", {SA, S3, SF, S7}, 4'b0000);
    wait_fd("wrap again");
    check_frame("wrap kept", {SA, S3, SF, S7}, 4'b0000);

    // Enable pause mid-slot of digit 1, with a direct load while paused.
    wait_fd("pause pre");
    repeat (5) tick();
    en_a = 1'b0;
    for (int p = 0; p < 10; p++) begin
      tick();
      load_a = 1'b0;
      chk_a($sformatf("paused p%0d", p), OFF, 1'b0, 4'b0000, 1'b0);
      if (p == 2) begin
        value_a = 16'h4321;
        dp_a    = 4'b0010;
        load_a  = 1'b1;
      end
    end
    en_a = 1'b1;
    tick();
    chk_a("resume r0", S2, 1'b1, 4'b0010, 1'b0);
    tick();
    chk_a("resume r1", S2, 1'b1, 4'b0010, 1'b0);
    tick();
    chk_a("resume r2", S3, 1'b0, 4'b0100, 1'b0);
    wait_fd("resume fd");
    check_frame("resume frame", {S4, S3, S2, S1}, 4'b0010);

    // Active-low pins: '8' drives all segments low, selected digit line low.
    value_b = 8'h88;
    dp_b    = 2'b01;
    load_b  = 1'b1;
    tick();
    load_b  = 1'b0;
    chk_b("pol idle", 7'b1111111, 1'b1, 2'b11, 1'b0);
    en_b = 1'b1;
    tick(); chk_b("pol d0 a", 7'b0000000, 1'b0, 2'b10, 1'b0);
    tick(); chk_b("pol d0 b", 7'b0000000, 1'b0, 2'b10, 1'b0);
    tick(); chk_b("pol d1 a", 7'b0000000, 1'b1, 2'b01, 1'b0);
    tick(); chk_b("pol d1 b", 7'b0000000, 1'b1, 2'b01, 1'b0);
    tick(); chk_b("pol wrap", 7'b0000000, 1'b0, 2'b10, 1'b1);
    en_b = 1'b0;

    // Asynchronous reset mid-slot with a load pending: pins clear without a clock edge.
    wait_fd("areset pre");
    repeat (5) tick();
    load_word(16'hFFFF, 4'b1111);
    #1 rst_n = 1'b0;
    #1;
    chk_a("areset a", OFF, 1'b0, 4'b0000, 1'b0);
    chk_b("areset b", 7'b1111111, 1'b1, 2'b11, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("areset resume", S0, 1'b0, 4'b0001, 1'b0);
    wait_fd("areset fd");
    check_frame("areset frame", {S0, S0, S0, S0}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for a bank of common-anode/cathode 7-segment digits, the parametrised successor of the single-digit hex decoder. It latches a packed hexadecimal word, decodes one nibble per scan slot into segments a–g (0–9, A–F), and drives one digit-select line at a time at a programmable refresh rate. It also supports optional leading-zero blanking, per-digit decimal points, and tear-free updates applied only at frame boundaries. It sits between the datapath registers and the board's display pins.

## Interface
- DIGITS, 4, number of digits scanned; legal 1..8
- REFRESH_DIV, 50000, clock cycles each digit stays selected; legal ≥2
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the pins
- DIG_ACTIVE_LOW, 0, 1 inverts digit_sel at the pins
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  4*DIGITS  hex word; nibble k (bits 4k+3:4k) shown on digit k; digit 0 is least significant
- dp_in  in  DIGITS  decimal-point request per digit
- load  in  1  capture value/dp_in this cycle
- blank_lz  in  1  enable leading-zero blanking
- enable  in  1  scanning enable
- seg  out  7  segments {a,b,c,d,e,f,g}, registered
- dp  out  1  decimal point, registered
- digit_sel  out  DIGITS  one-hot digit select, registered
- frame_done  out  1  one-cycle pulse when the last digit's slot ends

## Operation
- Decode, active-high before polarity: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- State registers:
  - pending word/dp
  - pending_valid flag
  - display word/dp
  - prescaler, 0..REFRESH_DIV-1
  - digit index, width max(1,$clog2(DIGITS)), 0..DIGITS-1
- load=1 captures value and dp_in into pending and sets pending_valid. A second load before transfer overwrites pending; only the last one is kept.
- Transfer pending→display happens only at frame wrap: prescaler at terminal, index = DIGITS-1, enable=1. pending_valid clears.
- If load coincides with frame wrap, the value presented that cycle goes straight to display and pending_valid stays 0.
- enable=0:
  - prescaler and index hold.
  - digit_sel and seg/dp are driven to the inactive level.
  - frame_done=0.
  - load transfers straight to display. Pending is bypassed and pending_valid is cleared.
- enable 0→1 resumes the held digit with the held prescaler count.
- Scan: the prescaler increments each enabled cycle. At terminal it goes to 0 and the index advances, wrapping DIGITS-1→0.
- Leading-zero blanking applies when blank_lz=1:
  - Digit k is blanked if its nibble and every higher nibble are 0. Digit 0 is never blanked.
  - A blanked digit has seg all inactive but keeps its digit_sel active.
  - dp is still shown on a blanked digit if its dp bit is set.
- DIGITS=1: the index is a constant 0 and every slot end is a frame wrap.

## Timing
- Reset values:
  - Outputs: seg=inactive (0000000, or 1111111 if SEG_ACTIVE_LOW), dp inactive, digit_sel all inactive, frame_done=0.
  - Internal state: pending, display and pending_valid are 0; prescaler=0; index=0.
- Outputs are registered from current state. In the first enabled cycle after rst_n rises, the outputs show digit 0 = '0' (segments 1111110).
- Each digit is selected for exactly REFRESH_DIV consecutive enabled cycles. A frame is DIGITS×REFRESH_DIV cycles.
- digit_sel changes on the same edge as seg/dp. No cycle shows the segments of one digit with the select of another.
- frame_done is high for the cycle in which digit 0 first appears after a wrap. It is simultaneous with the first display cycle of newly transferred data.
- Load latency to pins: 1 cycle to pending, then up to one frame until the wrap. The new data appears on digit 0 in the cycle after the wrap edge.
- rst_n assertion mid-frame clears all state immediately, asynchronously, and discards pending data.

## Test plan
- Reset → pins: hold rst_n=0 with defaults → seg=0000000, digit_sel=0000, frame_done=0. Release, enable=1 → digit_sel=0001 with seg=1111110 for 50000 cycles, then 0010.
- Full decode and scan: DIGITS=4, REFRESH_DIV=4, load value=16'hA3F7 → after wrap, slots show 7=1110000, F=1000111, 3=1111001, A=1110111 in order. frame_done pulses every 16 cycles.
- Tear-free update: load 16'h1234 mid-frame at digit 2 → remaining slots still show the old word; 1234 appears from the next digit 0. Two loads in one frame → only the second is ever displayed.
- Leading zeros: blank_lz=1, value=16'h0050, dp_in=4'b1000 → digits 3 and 2 are blank; dp is on in digit 3's slot; digit 1 shows 5 and digit 0 shows 0. value=0 → only digit 0 shows '0'.
- Enable and polarity:
  - enable=0 mid-slot for 10 cycles → all pins inactive. On re-enable, the same digit finishes its remaining count.
  - SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 → '8' appears as seg=0000000 with the selected digit_sel bit low.
- Simultaneous events:
  - load on the exact wrap cycle → the new word is shown on the next digit 0.
  - Asynchronous reset in mid-slot → outputs are inactive immediately, with no clock edge required.
